// File: rtl/alu_uart_host_if.sv
// ============================================================================
// Module      : alu_uart_host_if
// Description : FIFO-side bundle between the ALU link host and the UART core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_uart_host_if;
    logic       tx_full;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       rx_empty;
    logic       rd_uart;
    logic [7:0] r_data;

    modport master (
        input  tx_full,
        input  rx_empty,
        input  r_data,
        output wr_uart,
        output w_data,
        output rd_uart
    );

    modport slave (
        output tx_full,
        output rx_empty,
        output r_data,
        input  wr_uart,
        input  w_data,
        input  rd_uart
    );
endinterface

`default_nettype wire

// File: rtl/alu_uart_host.sv
// ============================================================================
// Module      : alu_uart_host
// Description : Sends one (a, b, op) frame over the UART FIFOs and waits for
//               the single result byte, with timeout and stray-byte dropping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_uart_host #(
    parameter int REG_SIZE       = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMO_W          = 20
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       start,
    input  wire logic signed [REG_SIZE-1:0] a_in,
    input  wire logic signed [REG_SIZE-1:0] b_in,
    input  wire logic        [REG_SIZE-1:0] op_in,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout,
    output logic                            stray_rx,
    output logic signed      [REG_SIZE-1:0] result,
    alu_uart_host_if.master                 uart
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_A   = 3'd1,
        ST_SEND_B   = 3'd2,
        ST_SEND_OP  = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_DONE     = 3'd5,
        ST_TMO      = 3'd6
    } state_t;

    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                     r_state_q,  w_state_d;
    logic signed [REG_SIZE-1:0] r_a_q,      w_a_d;
    logic signed [REG_SIZE-1:0] r_b_q,      w_b_d;
    logic        [REG_SIZE-1:0] r_op_q,     w_op_d;
    logic signed [REG_SIZE-1:0] r_result_q, w_result_d;
    logic        [TMO_W-1:0]    r_timer_q,  w_timer_d;

    logic       w_wr;
    logic [7:0] w_wdata;
    logic       w_rd;
    logic       w_stray;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_op_q     <= '0;
            r_result_q <= '0;
            r_timer_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_op_q     <= w_op_d;
            r_result_q <= w_result_d;
            r_timer_q  <= w_timer_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_op_d     = r_op_q;
        w_result_d = r_result_q;
        w_timer_d  = r_timer_q;
        w_wr       = 1'b0;
        w_wdata    = 8'h00;
        w_rd       = 1'b0;
        w_stray    = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                // Anything sitting in RX while idle is unsolicited; drain it.
                w_rd    = ~uart.rx_empty;
                w_stray = ~uart.rx_empty;
                if (start) begin
                    w_a_d     = a_in;
                    w_b_d     = b_in;
                    w_op_d    = op_in;
                    w_state_d = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                w_wdata = 8'(r_a_q);
                w_wr    = ~uart.tx_full;
                if (w_wr) w_state_d = ST_SEND_B;
            end
            ST_SEND_B: begin
                w_wdata = 8'(r_b_q);
                w_wr    = ~uart.tx_full;
                if (w_wr) w_state_d = ST_SEND_OP;
            end
            ST_SEND_OP: begin
                w_wdata = 8'(r_op_q);
                w_wr    = ~uart.tx_full;
                if (w_wr) begin
                    w_state_d = ST_WAIT_RES;
                    w_timer_d = '0;
                end
            end
            ST_WAIT_RES: begin
                w_rd = ~uart.rx_empty;
                if (!uart.rx_empty) begin
                    w_result_d = REG_SIZE'(uart.r_data);
                    w_state_d  = ST_DONE;
                end else if (r_timer_q == c_tmo_last) begin
                    w_state_d = ST_TMO;
                end else begin
                    w_timer_d = r_timer_q + 1'b1;
                end
            end
            ST_DONE:  w_state_d = ST_IDLE;
            ST_TMO:   w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // Strobes are forced low while reset is held so nothing is pushed or popped.
    assign uart.wr_uart = w_wr & ~reset;
    assign uart.w_data  = reset ? 8'h00 : w_wdata;
    assign uart.rd_uart = w_rd & ~reset;
    assign stray_rx     = w_stray & ~reset;
    assign busy         = (r_state_q != ST_IDLE) & ~reset;
    assign done         = (r_state_q == ST_DONE) & ~reset;
    assign timeout      = (r_state_q == ST_TMO) & ~reset;
    assign result       = r_result_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_uart_host.sv
// ============================================================================
// Module      : tb_alu_uart_host
// Description : Self-checking bench for alu_uart_host with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_uart_host;
    localparam int TMO  = 16;
    localparam int MAXC = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a_in, b_in, op_in;
    logic       busy, done, timeout, stray_rx;
    logic [7:0] result;

    alu_uart_host_if u_if ();

    alu_uart_host #(
        .REG_SIZE       (8),
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .op_in    (op_in),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .stray_rx (stray_rx),
        .result   (result),
        .uart     (u_if.master)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_result;
    logic [7:0] rx_q[$];

    logic       o_wr, o_rd, o_busy, o_done, o_tmo, o_stray;
    logic [7:0] o_wd, o_result;

    task automatic rx_load(input logic [7:0] d);
        rx_q.push_back(d);
        u_if.rx_empty = 1'b0;
        u_if.r_data   = rx_q[0];
    endtask

    // Sample mid-cycle, then advance past the edge and retire any popped byte.
    task automatic step();
        @(negedge clk);
        o_wr     = u_if.wr_uart;
        o_wd     = u_if.w_data;
        o_rd     = u_if.rd_uart;
        o_busy   = busy;
        o_done   = done;
        o_tmo    = timeout;
        o_stray  = stray_rx;
        o_result = result;
        @(posedge clk);
        #1;
        if (o_rd && rx_q.size() > 0) rx_q.delete(0);
        u_if.rx_empty = (rx_q.size() == 0);
        u_if.r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] reply, input int delay,
                             input int hold_until, input int bp_pct, input bit no_reply,
                             input bit stray_first, input bit poke);
        bit         full[MAXC];
        int         exp_push[3];
        logic [7:0] exp_byte[3];
        int         t, entry, reply_cyc, exp_rd, exp_done, exp_tmo, exp_idle, total, first_idle;
        int         push_t[$], rd_t[$], done_t[$], tmo_t[$], stray_t[$];
        logic [7:0] push_b[$];

        for (int c = 0; c < MAXC; c++)
            full[c] = (c >= 1 && c <= hold_until) ||
                      (c >= 1 && c <= 12 && int'($urandom_range(0, 99)) < bp_pct);
        exp_byte[0] = a; exp_byte[1] = b; exp_byte[2] = op;
        t = 1;
        for (int i = 0; i < 3; i++) begin
            while (full[t]) t++;
            exp_push[i] = t;
            t++;
        end
        entry     = t;
        reply_cyc = entry + delay;
        exp_rd    = reply_cyc;
        exp_done  = reply_cyc + 1;
        exp_tmo   = entry + TMO;
        exp_idle  = no_reply ? exp_tmo + 1 : reply_cyc + 2;
        if (!no_reply) exp_result = reply;
        total      = exp_idle + 6;
        first_idle = -1;

        a_in = a; b_in = b; op_in = op;
        for (int c = 0; c < total; c++) begin
            start = (c == 0) || (poke && (c == 2 || c == entry + 1));
            u_if.tx_full = (c < MAXC) ? full[c] : 1'b0;
            if (stray_first && c == 0) rx_load(8'h7F);
            if (!no_reply && c == reply_cyc) rx_load(reply);
            step();
            if (o_wr) begin push_t.push_back(c); push_b.push_back(o_wd); end
            if (o_rd && c > 0) rd_t.push_back(c);
            if (o_done) done_t.push_back(c);
            if (o_tmo) tmo_t.push_back(c);
            if (o_stray) stray_t.push_back(c);
            if (c > 0 && !o_busy && first_idle < 0) first_idle = c;
        end
        start = 1'b0;
        u_if.tx_full = 1'b0;

        checks++;
        if (push_t.size() != 3) begin
            errors++;
            $display("FAIL %s push_count: got %0d, expected 3", name, push_t.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (push_b[i] !== exp_byte[i]) begin
                    errors++;
                    $display("FAIL %s push_byte%0d: got %02h, expected %02h", name, i, push_b[i], exp_byte[i]);
                end
                checks++;
                if (push_t[i] != exp_push[i]) begin
                    errors++;
                    $display("FAIL %s push_cycle%0d: got %0d, expected %0d", name, i, push_t[i], exp_push[i]);
                end
            end
        end
        checks++;
        if (no_reply) begin
            if (rd_t.size() != 0 || done_t.size() != 0 || tmo_t.size() != 1 ||
                (tmo_t.size() == 1 && tmo_t[0] != exp_tmo)) begin
                errors++;
                $display("FAIL %s timeout_pulse: rd=%0d done=%0d tmo=%0d first_tmo=%0d, expected 0/0/1 at %0d",
                         name, rd_t.size(), done_t.size(), tmo_t.size(),
                         (tmo_t.size() > 0) ? tmo_t[0] : -1, exp_tmo);
            end
        end else begin
            if (rd_t.size() != 1 || done_t.size() != 1 || tmo_t.size() != 0 ||
                (rd_t.size() == 1 && rd_t[0] != exp_rd) ||
                (done_t.size() == 1 && done_t[0] != exp_done)) begin
                errors++;
                $display("FAIL %s reply: rd=%0d@%0d done=%0d@%0d tmo=%0d, expected 1@%0d 1@%0d 0",
                         name, rd_t.size(), (rd_t.size() > 0) ? rd_t[0] : -1,
                         done_t.size(), (done_t.size() > 0) ? done_t[0] : -1,
                         tmo_t.size(), exp_rd, exp_done);
            end
        end
        checks++;
        if (first_idle != exp_idle) begin
            errors++;
            $display("FAIL %s busy_low_cycle: got %0d, expected %0d", name, first_idle, exp_idle);
        end
        checks++;
        if (o_result !== exp_result) begin
            errors++;
            $display("FAIL %s result: got %02h, expected %02h", name, o_result, exp_result);
        end
        checks++;
        if (stray_first ? (stray_t.size() != 1 || stray_t[0] != 0) : (stray_t.size() != 0)) begin
            errors++;
            $display("FAIL %s stray_count: got %0d, expected %0d", name, stray_t.size(), stray_first ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({o_busy, o_done, o_tmo, o_stray, o_wr, o_rd, o_wd, o_result} !== 22'd0) begin
            errors++;
            $display("FAIL reset_hold outputs: got %b, expected all zero",
                     {o_busy, o_done, o_tmo, o_stray, o_wr, o_rd, o_wd, o_result});
        end
        reset = 1'b0;
        step();
        checks++;
        if ({o_busy, o_done, o_tmo, o_stray, o_wr, o_rd, o_wd, o_result} !== 22'd0) begin
            errors++;
            $display("FAIL reset_release outputs: got %b, expected all zero",
                     {o_busy, o_done, o_tmo, o_stray, o_wr, o_rd, o_wd, o_result});
        end
        exp_result = 8'h00;
    endtask

    task automatic test_basic();
        run_frame("basic", 8'h05, 8'h03, 8'h20, 8'h08, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", 8'h05, 8'h03, 8'h20, 8'h0A, 1, 4, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_frame("timeout", 8'h12, 8'h34, 8'h21, 8'h00, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stray();
        rx_load(8'h7F);
        step();
        checks++;
        if (o_rd !== 1'b1 || o_stray !== 1'b1 || o_result !== exp_result) begin
            errors++;
            $display("FAIL stray_idle: rd=%b stray=%b result=%02h, expected 1 1 %02h",
                     o_rd, o_stray, o_result, exp_result);
        end
        step();
        checks++;
        if (o_rd !== 1'b0 || o_stray !== 1'b0) begin
            errors++;
            $display("FAIL stray_after: rd=%b stray=%b, expected 0 0", o_rd, o_stray);
        end
        run_frame("stray_with_start", 8'h44, 8'h55, 8'h22, 8'h99, 3, 0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_frame("ignored_start", 8'h21, 8'h43, 8'h20, 8'h64, 3, 0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        a_in = 8'h11; b_in = 8'h22; op_in = 8'h20;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        exp_result = 8'h00;
        checks++;
        if (o_busy !== 1'b0 || o_wr !== 1'b0 || o_result !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_frame: busy=%b wr=%b result=%02h, expected 0 0 00",
                     o_busy, o_wr, o_result);
        end
        rx_load(8'h55);
        step();
        checks++;
        if (o_stray !== 1'b1 || o_result !== 8'h00) begin
            errors++;
            $display("FAIL late_reply_stray: stray=%b result=%02h, expected 1 00", o_stray, o_result);
        end
        step();
    endtask

    task automatic test_negative();
        run_frame("negative", 8'hFD, 8'hFF, 8'h20, 8'hFE, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++)
            run_frame("random", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 6)), 0, 35, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        a_in = 8'h00; b_in = 8'h00; op_in = 8'h00;
        u_if.tx_full = 1'b0; u_if.rx_empty = 1'b1; u_if.r_data = 8'h00;
        exp_result = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_stray();
        test_ignored_start();
        test_reset_mid_frame();
        test_negative();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
